// File: rtl/mem_access_ctrl.sv
// Sequences one load/store through MAR/MDR with a bounded wait on mem_ready.
// Latency: request edge to done = 4 cycles with zero-wait memory, +1 per extra wait cycle.
// Backpressure: requests are dropped while busy; mem_ready stretches the wait states up to TIMEOUT.
module mem_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic clr,
    input  logic req_rd,
    input  logic req_wr,
    input  logic mem_ready,
    output logic MARin,
    output logic MDRin,
    output logic read,
    output logic mem_rd,
    output logic mem_wr,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [2:0] {
        IDLE, ADDR, WDATA, RD_WAIT, WR_WAIT, RD_CAP, DONE, ERR
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic             op_rd, op_rd_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            op_rd <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            op_rd <= op_rd_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        op_rd_nxt = op_rd;
        cnt_nxt   = cnt;
        MARin     = 1'b0;
        MDRin     = 1'b0;
        read      = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                // Load has priority when both requests arrive together.
                if (req_rd || req_wr) begin
                    op_rd_nxt = req_rd;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                MARin     = 1'b1;
                state_nxt = op_rd ? RD_WAIT : WDATA;
            end
            WDATA: begin
                MDRin     = 1'b1;
                state_nxt = WR_WAIT;
            end
            RD_WAIT, WR_WAIT: begin
                mem_rd = (state == RD_WAIT);
                mem_wr = (state == WR_WAIT);
                // A ready on the last allowed cycle still completes normally.
                if (mem_ready) begin
                    cnt_nxt   = '0;
                    state_nxt = (state == RD_WAIT) ? RD_CAP : DONE;
                end else if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ERR;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RD_CAP: begin
                MDRin     = 1'b1;
                read      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            ERR: begin
                err       = 1'b1;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with TIMEOUT=8.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic req_rd = 1'b0;
    logic req_wr = 1'b0;
    logic mem_ready = 1'b0;
    logic MARin, MDRin, read, mem_rd, mem_wr, busy, done, err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic is_err;
        int   mar;
        int   rd;
        int   wr;
        int   mdrb;
        int   mdrm;
        int   lat;
    } exp_t;

    exp_t expq[$];

    mem_access_ctrl #(.TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .clr(clr), .req_rd(req_rd), .req_wr(req_wr),
        .mem_ready(mem_ready), .MARin(MARin), .MDRin(MDRin), .read(read),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: accumulate per-transaction activity, compare on done/err.
    int   c_mar, c_rd, c_wr, c_mdrb, c_mdrm, c_lat;
    logic prev_end = 1'b0;

    always @(negedge clk) begin
        if (!clr) begin
            c_mar = 0; c_rd = 0; c_wr = 0; c_mdrb = 0; c_mdrm = 0; c_lat = 0;
            prev_end = 1'b0;
        end else begin
            logic ok;
            ok = !(MARin && MDRin) && !(done && err) && !(read && (!MDRin || mem_rd))
                 && (busy || !(MARin || MDRin || read || mem_rd || mem_wr || done || err))
                 && !(prev_end && busy);
            chk("invariants", int'(ok), 1);
            prev_end = done || err;
            if (busy) begin
                c_mar  += int'(MARin);
                c_rd   += int'(mem_rd);
                c_wr   += int'(mem_wr);
                c_mdrb += int'(MDRin && !read);
                c_mdrm += int'(MDRin && read);
                c_lat  += 1;
            end
            if (done || err) begin
                if (expq.size() == 0) begin
                    chk("unexpected_completion", 1, 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("err_flag", int'(err), int'(e.is_err));
                    chk("marin_cycles", c_mar, e.mar);
                    chk("mem_rd_cycles", c_rd, e.rd);
                    chk("mem_wr_cycles", c_wr, e.wr);
                    chk("mdr_bus_cycles", c_mdrb, e.mdrb);
                    chk("mdr_mem_cycles", c_mdrm, e.mdrm);
                    chk("latency", c_lat, e.lat);
                end
                c_mar = 0; c_rd = 0; c_wr = 0; c_mdrb = 0; c_mdrm = 0; c_lat = 0;
            end
        end
    end

    task automatic push(input logic is_err, input int mar, input int rd, input int wr,
                        input int mdrb, input int mdrm, input int lat);
        exp_t e;
        e.is_err = is_err; e.mar = mar; e.rd = rd; e.wr = wr;
        e.mdrb = mdrb; e.mdrm = mdrm; e.lat = lat;
        expq.push_back(e);
    endtask

    task automatic issue(input logic rd, input logic wr);
        @(posedge clk); #1;
        req_rd = rd; req_wr = wr;
        @(posedge clk); #1;
        req_rd = 1'b0; req_wr = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
        repeat (2) @(negedge clk);
    endtask

    // Hold mem_ready low for n further cycles of a wait state, then pulse it.
    task automatic ready_after(input int n);
        int k = 0;
        @(negedge clk);
        while (!(mem_rd || mem_wr) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!(mem_rd || mem_wr)) chk("wait_state_timeout", 1, 0);
        repeat (n) @(posedge clk);
        #1 mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        @(negedge clk);
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!done) chk("done_timeout", 1, 0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_strobes", int'({MARin, MDRin, read, mem_rd, mem_wr, done, err}), 0);
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;

        // Load, zero-wait memory
        mem_ready = 1'b1;
        push(1'b0, 1, 1, 0, 0, 1, 4);
        issue(1'b1, 1'b0);
        wait_idle();

        // Store, ready delayed 3 cycles
        mem_ready = 1'b0;
        push(1'b0, 1, 0, 4, 1, 0, 7);
        fork
            issue(1'b0, 1'b1);
            ready_after(3);
        join
        wait_idle();

        // Timeout on load
        mem_ready = 1'b0;
        push(1'b1, 1, 8, 0, 0, 0, 10);
        issue(1'b1, 1'b0);
        wait_idle();

        // Simultaneous requests: load only; store pulsed while busy is ignored
        mem_ready = 1'b1;
        push(1'b0, 1, 1, 0, 0, 1, 4);
        issue(1'b1, 1'b1);
        #1 req_wr = 1'b1;
        @(posedge clk); #1 req_wr = 1'b0;
        wait_idle();
        repeat (8) @(negedge clk);

        // Back-to-back load then store
        mem_ready = 1'b1;
        push(1'b0, 1, 1, 0, 0, 1, 4);
        push(1'b0, 1, 0, 1, 1, 0, 4);
        issue(1'b1, 1'b0);
        wait_done();
        @(posedge clk); #1 req_wr = 1'b1;
        @(posedge clk); #1 req_wr = 1'b0;
        @(negedge clk);
        chk("b2b_accepted", int'(busy), 1);
        wait_idle();

        // Reset mid RD_WAIT drops the transaction
        mem_ready = 1'b0;
        issue(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #3 clr = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_mem_rd", int'(mem_rd), 0);
        chk("midrst_strobes", int'({MARin, MDRin, read, mem_wr, done, err}), 0);
        @(posedge clk); #1 clr = 1'b1;

        // Normal load after reset release
        mem_ready = 1'b1;
        push(1'b0, 1, 1, 0, 0, 1, 4);
        issue(1'b1, 1'b0);
        wait_idle();

        repeat (5) @(negedge clk);
        chk("pending_expected", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
